encoder_poll_sched: RTL

//  Schedules encoder acquisitions on the encoder-data top level: drives its data-acquire trigger (key) and waits for the frame result.

---
 rtl/encoder_poll_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/encoder_poll_sched.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_poll_sched
//  Purpose  : Schedules encoder acquisitions. Merges a periodic poll timer and
//             single-shot host requests into one transaction stream, pulses
//             the encoder key, waits for the frame result, retries on bad CRC
//             or timeout, and reports good samples or abandoned transactions.
//  Options  : STAMP_EN - capture a free-running cycle count at each key rising
//             edge and publish it as sample_stamp with every good sample.
//  Revision : 1.0 - initial release
// ============================================================================
module encoder_poll_sched #(
  parameter int KEY_WIDTH   = 10,
  parameter int TIMEOUT_CYC = 5000,
  parameter int GAP_CYC     = 200,
  parameter int MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] period,
  input  logic        host_req,
  input  logic        frame_done,
  input  logic        crc_ok,
  input  logic [31:0] frame_data,
  output logic        key,
  output logic        busy,
  output logic        sample_valid,
  output logic [31:0] sample_data,
  output logic        fail_pulse,
  output logic [15:0] fail_cnt,
  output logic [31:0] sample_stamp
);

  localparam logic [31:0] KEY_LAST  = 32'(KEY_WIDTH - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [7:0]  retry_cnt;
  logic [23:0] per_cnt;
  logic        poll_pend, host_pend;
  logic        tmr_run, tmr_wrap;
  logic        start, good, retry, give_up;

  // Timer runs only when polling is enabled with a non-zero period; the >=
  // compare lets a shrunk period take effect without a full 24-bit wrap.
  assign tmr_run  = enable && (period != 24'd0);
  assign tmr_wrap = tmr_run && (per_cnt >= (period - 24'd1));

  // Poll period counter
  always_ff @(posedge clk) begin
    if (rst || !tmr_run) per_cnt <= 24'd0;
    else if (tmr_wrap)   per_cnt <= 24'd0;
    else                 per_cnt <= per_cnt + 24'd1;
  end

  // Pending request flags; a new request on the clearing cycle wins
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_pend <= 1'b0;
      host_pend <= 1'b0;
    end else begin
      if (!tmr_run)     poll_pend <= 1'b0;
      else if (tmr_wrap) poll_pend <= 1'b1;
      else if (start)   poll_pend <= 1'b0;
      if (host_req)     host_pend <= 1'b1;
      else if (start)   host_pend <= 1'b0;
    end
  end

  // Next-state and transaction decisions; frame_done beats a same-cycle timeout
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    good      = 1'b0;
    retry     = 1'b0;
    give_up   = 1'b0;
    case (state)
      S_IDLE: begin
        if (poll_pend || host_pend) begin
          state_nxt = S_TRIG;
          start     = 1'b1;
        end
      end
      S_TRIG: begin
        if (cnt == KEY_LAST) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (frame_done && crc_ok) begin
          good      = 1'b1;
          state_nxt = S_IDLE;
        end else if (frame_done || (cnt == TMO_LAST)) begin
          if (retry_cnt < RETRY_MAX) begin
            retry     = 1'b1;
            state_nxt = S_GAP;
          end else begin
            give_up   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_nxt = S_TRIG;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, per-state cycle counter and retry count
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 32'd0;
      retry_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (state == S_IDLE)) cnt <= 32'd0;
      else                                           cnt <= cnt + 32'd1;
      if (start)      retry_cnt <= 8'd0;
      else if (retry) retry_cnt <= retry_cnt + 8'd1;
    end
  end

  // Registered outputs: key follows TRIG one cycle late, result strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      key          <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= 32'd0;
      fail_pulse   <= 1'b0;
      fail_cnt     <= 16'd0;
    end else begin
      key          <= (state == S_TRIG);
      sample_valid <= good;
      fail_pulse   <= give_up;
      if (good) sample_data <= frame_data;
      if (give_up && (fail_cnt != 16'hFFFF)) fail_cnt <= fail_cnt + 16'd1;
    end
  end

  assign busy = (state != S_IDLE);

`ifdef STAMP_EN
  logic [31:0] cyc;
  logic [31:0] stamp_cap;

  // Free-running cycle count, captured as the count of the first key-high cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc          <= 32'd0;
      stamp_cap    <= 32'd0;
      sample_stamp <= 32'd0;
    end else begin
      cyc <= cyc + 32'd1;
      if ((state == S_TRIG) && !key) stamp_cap <= cyc + 32'd1;
      if (good) sample_stamp <= stamp_cap;
    end
  end
`else
  assign sample_stamp = 32'h0;
`endif

endmodule
`default_nettype wire
